// File: rtl/instr_fetch_pkg.sv
// Shared fetch types and constants: sequencer states, halt encoding, opcodes and
// the absolute branch-target table used when relative branching is not built in.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH,
    DONE
  } fetch_state_t;

  localparam logic [8:0] HALT_WORD = 9'h1FF;

  localparam logic [3:0] OP_ALU = 4'h0;
  localparam logic [3:0] OP_BEQ = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;

  // Entries are wide enough for any supported PC_W; users truncate to PC_W.
  localparam logic [15:0] BRANCH_LUT [16] = '{
    16'd0,   16'd4,   16'd10,  16'd20,
    16'd40,  16'd64,  16'd100, 16'd128,
    16'd200, 16'd256, 16'd300, 16'd512,
    16'd30,  16'd700, 16'd900, 16'd1020
  };

endpackage

// File: rtl/instr_fetch_branch_lut.sv
// Absolute branch-target lookup: 4-bit index from the instruction to a PC.
module branch_lut
  import instr_fetch_pkg::*;
#(
  parameter int unsigned PC_W = 10
) (
  input  logic [3:0]      idx,
  output logic [PC_W-1:0] target
);

  assign target = PC_W'(BRANCH_LUT[idx]);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: PC, synchronous ROM addressing, branch/halt/start.
// Define FETCH_REL_BRANCH_EN for PC-relative branch targets instead of the LUT.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 9
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [PC_W-1:0]    StartAddr,
  input  logic               Stall,
  input  logic               Branch,
  input  logic               Cond,
  output logic [PC_W-1:0]    IMemAddr,
  input  logic [INSTR_W-1:0] IMemData,
  output logic [INSTR_W-1:0] Instr_o,
  output logic [3:0]         Opcode,
  output logic               InstrValid,
  output logic [PC_W-1:0]    CurPC,
  output logic               Busy,
  output logic               Done
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] cur_pc;
  logic [PC_W-1:0] target;
  logic            is_halt;
  logic            taken;

  assign is_halt    = (IMemData == INSTR_W'(HALT_WORD));
  // A stalled halt word is still presented; it only retires the fetch when unstalled.
  assign InstrValid = (state == RUN) && (Stall || !is_halt);
  assign Instr_o    = InstrValid ? IMemData : '0;
  assign Opcode     = Instr_o[INSTR_W-1 -: 4];
  assign CurPC      = cur_pc;
  assign IMemAddr   = (state == RUN && Stall) ? cur_pc : pc;
  assign Busy       = (state == FILL) || (state == RUN) || (state == FLUSH);
  assign Done       = (state == DONE);
  assign taken      = Branch && Cond;

`ifdef FETCH_REL_BRANCH_EN
  assign target = cur_pc + PC_W'($signed(Instr_o[4:0]));
`else
  branch_lut #(
    .PC_W(PC_W)
  ) u_branch_lut (
    .idx   (Instr_o[3:0]),
    .target(target)
  );
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      pc     <= '0;
      cur_pc <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            pc    <= StartAddr;
            state <= FILL;
          end
        end
        FILL, FLUSH: begin
          cur_pc <= pc;
          pc     <= pc + PC_W'(1);
          state  <= RUN;
        end
        RUN: begin
          if (!Stall) begin
            if (is_halt) begin
              state <= DONE;
            end else if (taken) begin
              pc    <= target;
              state <= FLUSH;
            end else begin
              cur_pc <= pc;
              pc     <= pc + PC_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: program-trace reference model feeds a queue,
// a negedge monitor checks issued instructions, bubble counts and halt timing.
module tb_instr_fetch;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int ROM_N   = 1024;
  localparam logic [8:0] T_HALT = 9'h1FF;
  localparam logic [3:0] T_BEQ  = 4'h1;

  logic               Clk = 1'b0;
  logic               Reset_n = 1'b0;
  logic               Start = 1'b0;
  logic [PC_W-1:0]    StartAddr = '0;
  logic               Stall = 1'b0;
  logic               Branch;
  logic               Cond;
  logic [PC_W-1:0]    IMemAddr;
  logic [INSTR_W-1:0] IMemData = '0;
  logic [INSTR_W-1:0] Instr_o;
  logic [3:0]         Opcode;
  logic               InstrValid;
  logic [PC_W-1:0]    CurPC;
  logic               Busy;
  logic               Done;

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .Branch(Branch), .Cond(Cond), .IMemAddr(IMemAddr),
    .IMemData(IMemData), .Instr_o(Instr_o), .Opcode(Opcode),
    .InstrValid(InstrValid), .CurPC(CurPC), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  logic [8:0] rom [ROM_N];
  bit         cond_tbl [ROM_N];
  int         tb_lut [16] = '{0, 4, 10, 20, 40, 64, 100, 128,
                              200, 256, 300, 512, 30, 700, 900, 1020};

  always @(posedge Clk) IMemData <= rom[IMemAddr];
  assign Branch = (Opcode == T_BEQ);
  assign Cond   = cond_tbl[CurPC];

  typedef struct {
    int         pc;
    logic [8:0] w;
    int         gap;
    bit         halt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err = 0;
  bit   start_now = 0;
  int   gap = 0;
  bit   front_seen = 0;

  int   stall_mode = 0;
  int   stall_pc = 0;
  int   stall_left = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_target(input int pc, input logic [8:0] w);
`ifdef FETCH_REL_BRANCH_EN
    int off;
    off = w[4] ? int'(w[4:0]) - 32 : int'(w[4:0]);
    return (pc + off + ROM_N) % ROM_N;
`else
    return tb_lut[w[3:0]];
`endif
  endfunction

  // Architectural walk of the program: what retires, and how many dead cycles precede it.
  function automatic void build_trace(input int sa, input int maxn);
    int pc;
    int pend;
    logic [8:0] w;
    pc = sa;
    pend = 1;
    for (int n = 0; n < maxn; n++) begin
      w = rom[pc];
      if (w == T_HALT) begin
        q.push_back('{pc, w, pend + 1, 1'b1});
        return;
      end
      q.push_back('{pc, w, pend, 1'b0});
      if (w[8:5] == T_BEQ && cond_tbl[pc]) begin
        pc = model_target(pc, w);
        pend = 1;
      end else begin
        pc = (pc + 1) % ROM_N;
        pend = 0;
      end
    end
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    if (!Reset_n) begin
      gap = 0;
    end else if (start_now) begin
      gap = 0;
      front_seen = 0;
    end else if (q.size() != 0) begin
      e = q[0];
      if (e.halt) begin
        if (InstrValid) begin
          check("halt_hold_pc", CurPC, e.pc);
          check("halt_hold_instr", Instr_o, e.w);
        end else if (Done) begin
          check("halt_done_gap", gap, e.gap);
          check("done_busy", Busy, 0);
          void'(q.pop_front());
        end else begin
          gap++;
        end
      end else if (InstrValid) begin
        if (!front_seen) begin
          check("issue_gap", gap, e.gap);
          front_seen = 1;
        end
        check("cur_pc", CurPC, e.pc);
        check("instr", Instr_o, e.w);
        check("opcode", Opcode, e.w[8:5]);
        check("busy", Busy, 1);
        if (!Stall) begin
          void'(q.pop_front());
          gap = 0;
          front_seen = 0;
        end
      end else begin
        gap++;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, InstrValid, 0);
    check({tag, "_instr"}, Instr_o, 0);
    check({tag, "_opcode"}, Opcode, 0);
    check({tag, "_curpc"}, CurPC, 0);
    check({tag, "_addr"}, IMemAddr, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
  endtask

  task automatic mid_reset();
    Stall = 1'b0;
    #2 Reset_n = 1'b0;
    #1 check_zero("async_rst");
    @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  task automatic run_prog(input int sa, input int maxn, input bit pulse_mid);
    @(posedge Clk);
    #1;
    build_trace(sa, maxn);
    StartAddr = PC_W'(sa);
    Start = 1'b1;
    start_now = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    start_now = 1'b0;
    for (int c = 0; c < 3000 && q.size() != 0; c++) begin
      @(posedge Clk);
      #1;
      if (stall_mode == 1) begin
        Stall = ($urandom_range(0, 3) == 0);
      end else if (stall_mode == 2) begin
        if (InstrValid && CurPC == PC_W'(stall_pc) && stall_left > 0) begin
          Stall = 1'b1;
          stall_left--;
        end else begin
          Stall = 1'b0;
        end
      end else begin
        Stall = 1'b0;
      end
      Start = pulse_mid && (c == 4);
      StartAddr = Start ? PC_W'(100) : StartAddr;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL run_timeout: %0d entries left, expected 0 (start %0d)", q.size(), sa);
      q.delete();
    end
    Start = 1'b0;
    Stall = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < ROM_N; i++) begin
      rom[i] = 9'h000;
      cond_tbl[i] = 1'b0;
    end
    rom[5] = 9'h012;  rom[6] = 9'h034;  rom[7] = 9'h056;
    rom[8] = 9'h023;  rom[9] = 9'h045;  rom[10] = T_HALT;
    rom[11] = T_HALT; rom[12] = 9'h03C; rom[20] = 9'h061;
    rom[21] = T_HALT; rom[30] = T_HALT; rom[40] = T_HALT;
    rom[1018] = T_HALT;
    rom[1023] = 9'h001; rom[0] = 9'h002; rom[1] = 9'h003; rom[2] = 9'h004;

    #3 check_zero("reset");
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Sequential run, Start during RUN ignored, then halt.
    run_prog(5, 50, 1'b1);
    // Restart from DONE with a taken branch at 8.
    cond_tbl[8] = 1'b1;
    run_prog(5, 50, 1'b0);
    // Three-cycle stall on a taken branch at 6.
    cond_tbl[8] = 1'b0;
    cond_tbl[6] = 1'b1;
    stall_mode = 2;
    stall_pc = 6;
    stall_left = 3;
    run_prog(5, 50, 1'b0);
    stall_mode = 0;
    cond_tbl[6] = 1'b0;
    // Branch at 12 with low bits 5'b11100.
    cond_tbl[12] = 1'b1;
    run_prog(12, 50, 1'b0);
    cond_tbl[12] = 1'b0;
    // PC wrap 1023 -> 0, then reset while running.
    run_prog(1023, 3, 1'b0);
    mid_reset();

    stall_mode = 1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < ROM_N; i++) begin
        int k;
        logic [8:0] w;
        k = $urandom_range(0, 15);
        w = 9'($urandom);
        if (k == 0) w = T_HALT;
        else if (k < 5) w = {T_BEQ, 5'($urandom)};
        else if (w == T_HALT) w = 9'h000;
        rom[i] = w;
        cond_tbl[i] = 1'($urandom);
      end
      run_prog((r == 0) ? 1023 : int'($urandom_range(0, ROM_N - 1)), 40, 1'b0);
      mid_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
